// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the Pico UART command responder.
package uart_cmd_pkg;

  localparam logic [7:0] SOF_REQ   = 8'hAA;
  localparam logic [7:0] SOF_RSP   = 8'h55;
  localparam logic [7:0] PING_VAL  = 8'hA5;
  localparam logic [7:0] CTRL_BASE = 8'h80;

  typedef enum logic [7:0] {
    CMD_READ  = 8'h01,
    CMD_WRITE = 8'h02,
    CMD_PING  = 8'h03
  } cmd_e;

  typedef enum logic [7:0] {
    ST_OK       = 8'h00,
    ST_BAD_CHK  = 8'h01,
    ST_BAD_CMD  = 8'h02,
    ST_BAD_ADDR = 8'h03
  } status_e;

  typedef enum logic [2:0] {
    S_SOF, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_TX_LOAD, S_TX_WAIT
  } state_e;

  // Response frame, byte 0 goes on the wire first.
  typedef logic [3:0][7:0] resp_t;

endpackage

// File: rtl/uart_resp_serializer.sv
// Pushes a 4-byte response frame through the UART transmitter's
// tx_dv / tx_active / tx_done byte handshake.
module uart_resp_serializer
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  resp_t      resp,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  output logic       last
);

  // S_SOF doubles as the idle state here.
  state_e     st;
  logic [1:0] idx;
  resp_t      rsp_q;

  assign last = (st == S_TX_WAIT) && tx_done && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= S_SOF;
      idx     <= 2'd0;
      rsp_q   <= '0;
      tx_dv   <= 1'b0;
      tx_byte <= 8'h00;
    end else begin
      tx_dv <= 1'b0;
      case (st)
        S_TX_LOAD: begin
          if (!tx_active) begin
            tx_dv   <= 1'b1;
            tx_byte <= rsp_q[idx];
            st      <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          if (tx_done) begin
            if (idx == 2'd3) begin
              st <= S_SOF;
            end else begin
              idx <= idx + 2'd1;
              // Fire straight from the done cycle so the next byte follows by one clock.
              if (!tx_active) begin
                tx_dv   <= 1'b1;
                tx_byte <= rsp_q[idx + 2'd1];
              end else begin
                st <= S_TX_LOAD;
              end
            end
          end
        end
        default: begin
          if (start) begin
            rsp_q <= resp;
            idx   <= 2'd0;
            if (!tx_active) begin
              tx_dv   <= 1'b1;
              tx_byte <= resp[0];
              st      <= S_TX_WAIT;
            end else begin
              st <= S_TX_LOAD;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses 5-byte request frames from the Pico, executes read/write/ping on the
// status and control registers, and returns a 4-byte response.
// Optional inter-byte timeout: define UART_RESP_TIMEOUT_EN.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int NUM_RO       = 8,
  parameter int NUM_CTRL     = 4,
  parameter int TIMEOUT_CLKS = 25_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx_dv,
  input  logic [7:0]            i_rx_byte,
  output logic                  o_tx_dv,
  output logic [7:0]            o_tx_byte,
  input  logic                  i_tx_active,
  input  logic                  i_tx_done,
  input  logic [8*NUM_RO-1:0]   i_ro_regs,
  output logic [8*NUM_CTRL-1:0] o_ctrl_regs,
  output logic                  o_wr_strobe,
  output logic                  o_busy,
  output logic [7:0]            o_err_cnt
);

  state_e                    state;
  logic [7:0]                cmd, addr, data, chk;
  logic [NUM_CTRL-1:0][7:0]  ctrl;
  status_e                   status;
  logic [7:0]                rdata, rd_val;
  logic                      is_ro, is_ctrl;
  resp_t                     resp;
  logic                      ser_last;

  assign o_ctrl_regs = ctrl;

  always_comb begin
    is_ro   = 1'b0;
    is_ctrl = 1'b0;
    rd_val  = 8'h00;
    for (int k = 0; k < NUM_RO; k++)
      if (addr == 8'(k)) begin
        is_ro  = 1'b1;
        rd_val = i_ro_regs[8*k +: 8];
      end
    for (int k = 0; k < NUM_CTRL; k++)
      if (addr == CTRL_BASE + 8'(k)) begin
        is_ctrl = 1'b1;
        rd_val  = ctrl[k];
      end

    status = ST_OK;
    rdata  = 8'h00;
    if ((cmd ^ addr ^ data) != chk)
      status = ST_BAD_CHK;
    else if (cmd != CMD_READ && cmd != CMD_WRITE && cmd != CMD_PING)
      status = ST_BAD_CMD;
    else if ((cmd == CMD_READ && !(is_ro || is_ctrl)) || (cmd == CMD_WRITE && !is_ctrl))
      status = ST_BAD_ADDR;
    else if (cmd == CMD_READ)
      rdata = rd_val;
    else if (cmd == CMD_WRITE)
      rdata = data;
    else
      rdata = PING_VAL;

    resp = {8'(status) ^ rdata, rdata, 8'(status), SOF_RSP};
  end

`ifdef UART_RESP_TIMEOUT_EN
  logic [31:0] gap_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = |32'(TIMEOUT_CLKS);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= S_SOF;
      cmd         <= 8'h00;
      addr        <= 8'h00;
      data        <= 8'h00;
      chk         <= 8'h00;
      ctrl        <= '0;
      o_wr_strobe <= 1'b0;
      o_busy      <= 1'b0;
      o_err_cnt   <= 8'h00;
`ifdef UART_RESP_TIMEOUT_EN
      gap_cnt     <= 32'd0;
`endif
    end else begin
      o_wr_strobe <= 1'b0;
      case (state)
        S_SOF: if (i_rx_dv && i_rx_byte == SOF_REQ) begin
          state  <= S_CMD;
          o_busy <= 1'b1;
        end
        S_CMD:  if (i_rx_dv) begin cmd  <= i_rx_byte; state <= S_ADDR; end
        S_ADDR: if (i_rx_dv) begin addr <= i_rx_byte; state <= S_DATA; end
        S_DATA: if (i_rx_dv) begin data <= i_rx_byte; state <= S_CHK;  end
        S_CHK:  if (i_rx_dv) begin chk  <= i_rx_byte; state <= S_EXEC; end
        S_EXEC: begin
          if (status != ST_OK) begin
            if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
          end else if (cmd == CMD_WRITE) begin
            for (int k = 0; k < NUM_CTRL; k++)
              if (addr == CTRL_BASE + 8'(k)) ctrl[k] <= data;
            o_wr_strobe <= 1'b1;
          end
          state <= S_TX_WAIT;
        end
        S_TX_WAIT: if (ser_last) begin
          state  <= S_SOF;
          o_busy <= 1'b0;
        end
        default: state <= S_SOF;
      endcase

`ifdef UART_RESP_TIMEOUT_EN
      // Abandon a stalled partial frame; this overrides the parse step above.
      if (state == S_CMD || state == S_ADDR || state == S_DATA || state == S_CHK) begin
        if (i_rx_dv) begin
          gap_cnt <= 32'd0;
        end else if (gap_cnt == 32'(TIMEOUT_CLKS - 1)) begin
          gap_cnt <= 32'd0;
          state   <= S_SOF;
          o_busy  <= 1'b0;
          if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
        end else begin
          gap_cnt <= gap_cnt + 32'd1;
        end
      end else begin
        gap_cnt <= 32'd0;
      end
`endif
    end
  end

  uart_resp_serializer u_ser (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .start     (state == S_EXEC),
    .resp      (resp),
    .tx_active (i_tx_active),
    .tx_done   (i_tx_done),
    .tx_dv     (o_tx_dv),
    .tx_byte   (o_tx_byte),
    .last      (ser_last)
  );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Randomized self-checking bench for uart_cmd_responder with a frame-level model
// and a behavioural UART transmitter.
module tb_uart_cmd_responder;

  localparam int NRO = 8;
  localparam int NCT = 4;
  localparam int TO  = 64;

  logic              i_clk, i_rst_n, i_rx_dv;
  logic [7:0]        i_rx_byte;
  logic              o_tx_dv;
  logic [7:0]        o_tx_byte;
  logic              i_tx_active, i_tx_done;
  logic [8*NRO-1:0]  i_ro_regs;
  logic [8*NCT-1:0]  o_ctrl_regs;
  logic              o_wr_strobe, o_busy;
  logic [7:0]        o_err_cnt;

  int total = 0, bad = 0, strobe_cnt = 0;
  logic [7:0] txq[$];
  logic [7:0] ro_m[NRO];
  logic [7:0] ctrl_m[NCT];
  int err_m = 0;

  uart_cmd_responder #(.NUM_RO(NRO), .NUM_CTRL(NCT), .TIMEOUT_CLKS(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte), .i_tx_active(i_tx_active),
    .i_tx_done(i_tx_done), .i_ro_regs(i_ro_regs), .o_ctrl_regs(o_ctrl_regs),
    .o_wr_strobe(o_wr_strobe), .o_busy(o_busy), .o_err_cnt(o_err_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial forever begin
    @(negedge i_clk);
    if (o_wr_strobe === 1'b1) strobe_cnt++;
  end

  // Behavioural transmitter: busy for a random time, then done with active low.
  initial begin : tx_model
    int resp_idx;
    bit prev_done, aborted;
    logic [7:0] cur;
    resp_idx = 0;
    i_tx_active = 1'b0;
    i_tx_done = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      prev_done = i_tx_done;
      i_tx_done = 1'b0;
      if (!i_rst_n) resp_idx = 0;
      if (prev_done && resp_idx != 0) begin
        total++;
        if (o_tx_dv !== 1'b1) begin bad++; $display("FAIL tx_gap dv=%b want 1", o_tx_dv); end
      end
      if (o_tx_dv === 1'b1) begin
        cur = o_tx_byte;
        txq.push_back(cur);
        resp_idx = (resp_idx + 1) % 4;
        aborted = 1'b0;
        i_tx_active = 1'b1;
        repeat ($urandom_range(2, 6)) begin
          @(posedge i_clk); #1;
          if (!i_rst_n) begin aborted = 1'b1; resp_idx = 0; end
          if (!aborted) begin
            total++;
            if (o_tx_byte !== cur || o_tx_dv !== 1'b0) begin
              bad++;
              $display("FAIL tx_hold byte=%h dv=%b want byte=%h dv=0", o_tx_byte, o_tx_dv, cur);
            end
          end
        end
        i_tx_active = 1'b0;
        i_tx_done = 1'b1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_byte = b;
    i_rx_dv = 1'b1;
    @(posedge i_clk); #1;
    i_rx_dv = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, a, d, k);
    logic [7:0] fr[4];
    fr = '{c, a, d, k};
    send_byte(8'hAA);
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 1));
      send_byte(fr[i]);
    end
  endtask

  task automatic drive_ro();
    for (int k = 0; k < NRO; k++) i_ro_regs[8*k +: 8] = ro_m[k];
  endtask

  function automatic logic [8*NCT-1:0] ctrl_vec();
    logic [8*NCT-1:0] v;
    for (int k = 0; k < NCT; k++) v[8*k +: 8] = ctrl_m[k];
    return v;
  endfunction

  // Frame-level reference: response word (first byte in MSB), updates model state.
  task automatic model_frame(input logic [7:0] c, a, d, k, output logic [31:0] rsp, output bit wr);
    logic [7:0] st, rd;
    bit ro_a, ct_a;
    ro_a = int'(a) < NRO;
    ct_a = int'(a) >= 128 && int'(a) < 128 + NCT;
    st = 8'h00; rd = 8'h00; wr = 1'b0;
    if ((c ^ a ^ d) != k) st = 8'h01;
    else if (c < 8'h01 || c > 8'h03) st = 8'h02;
    else if ((c == 8'h01 && !(ro_a || ct_a)) || (c == 8'h02 && !ct_a)) st = 8'h03;
    else if (c == 8'h01) rd = ro_a ? ro_m[int'(a)] : ctrl_m[int'(a) - 128];
    else if (c == 8'h02) begin rd = d; ctrl_m[int'(a) - 128] = d; wr = 1'b1; end
    else rd = 8'hA5;
    if (st != 8'h00 && err_m != 255) err_m++;
    rsp = {8'h55, st, rd, st ^ rd};
  endtask

  task automatic wait_resp(output logic [31:0] got, output bit ok, output int cnt);
    int n;
    n = 0;
    while (n < 3000 && !(txq.size() >= 4 && o_busy === 1'b0)) begin idle(1); n++; end
    cnt = txq.size();
    ok = (n < 3000);
    got = (cnt >= 4) ? {txq[0], txq[1], txq[2], txq[3]} : 32'h0;
    txq.delete();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_rx_dv = 1'b0; i_rx_byte = 8'h00;
    for (int k = 0; k < NRO; k++) ro_m[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < NCT; k++) ctrl_m[k] = 8'h00;
    drive_ro();
    idle(3);
    total++; if (o_tx_dv !== 1'b0) begin bad++; $display("FAIL rst_tx_dv got=%b want 0", o_tx_dv); end
    total++; if (o_tx_byte !== 8'h00) begin bad++; $display("FAIL rst_tx_byte got=%h want 00", o_tx_byte); end
    total++; if (o_ctrl_regs !== '0) begin bad++; $display("FAIL rst_ctrl got=%h want 0", o_ctrl_regs); end
    total++; if (o_wr_strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe got=%b want 0", o_wr_strobe); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want 0", o_busy); end
    total++; if (o_err_cnt !== 8'h00) begin bad++; $display("FAIL rst_err got=%h want 00", o_err_cnt); end
    i_rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_read();
    logic [31:0] got, exp; bit ok, wr; int cnt;
    ro_m[2] = 8'h3C; drive_ro();
    model_frame(8'h01, 8'h02, 8'h00, 8'h03, exp, wr);
    send_byte(8'hAA);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL read_busy_rise got=%b want 1", o_busy); end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h00); send_byte(8'h03);
    idle(1);
    total++; if (o_tx_dv !== 1'b1 || o_tx_byte !== 8'h55) begin
      bad++; $display("FAIL read_first_dv dv=%b byte=%h want dv=1 byte=55", o_tx_dv, o_tx_byte); end
    wait_resp(got, ok, cnt);
    total++; if (!ok || got !== 32'h55003C3C) begin
      bad++; $display("FAIL read_resp got=%h ok=%0d want 55003c3c", got, ok); end
    total++; if (exp !== 32'h55003C3C) begin bad++; $display("FAIL read_model got=%h want 55003c3c", exp); end
  endtask

  task automatic test_write();
    logic [31:0] got, exp; bit ok, wr; int cnt, s0;
    s0 = strobe_cnt;
    model_frame(8'h02, 8'h81, 8'h7E, 8'hFD, exp, wr);
    send_frame(8'h02, 8'h81, 8'h7E, 8'hFD);
    idle(1);
    total++; if (o_wr_strobe !== 1'b1 || o_ctrl_regs[15:8] !== 8'h7E) begin
      bad++; $display("FAIL write_n2 strobe=%b ctrl1=%h want 1/7e", o_wr_strobe, o_ctrl_regs[15:8]); end
    wait_resp(got, ok, cnt);
    total++; if (!ok || got !== 32'h55007E7E) begin bad++; $display("FAIL write_resp got=%h want 55007e7e", got); end
    total++; if (strobe_cnt - s0 != 1) begin bad++; $display("FAIL write_strobes got=%0d want 1", strobe_cnt - s0); end
    total++; if (o_ctrl_regs !== ctrl_vec()) begin bad++; $display("FAIL write_ctrl got=%h want %h", o_ctrl_regs, ctrl_vec()); end
  endtask

  task automatic test_errors();
    logic [31:0] got, exp; bit ok, wr; int cnt, s0;
    s0 = strobe_cnt;
    model_frame(8'h01, 8'h02, 8'h00, 8'h00, exp, wr);
    send_frame(8'h01, 8'h02, 8'h00, 8'h00);
    wait_resp(got, ok, cnt);
    total++; if (got !== 32'h55010001) begin bad++; $display("FAIL badchk_resp got=%h want 55010001", got); end
    total++; if (o_err_cnt !== 8'd1) begin bad++; $display("FAIL badchk_err got=%0d want 1", o_err_cnt); end
    model_frame(8'h02, 8'h03, 8'h11, 8'h10, exp, wr);
    send_frame(8'h02, 8'h03, 8'h11, 8'h10);
    wait_resp(got, ok, cnt);
    total++; if (got !== 32'h55030003) begin bad++; $display("FAIL ro_write_resp got=%h want 55030003", got); end
    model_frame(8'h07, 8'h00, 8'h00, 8'h07, exp, wr);
    send_frame(8'h07, 8'h00, 8'h00, 8'h07);
    wait_resp(got, ok, cnt);
    total++; if (got !== 32'h55020002) begin bad++; $display("FAIL badcmd_resp got=%h want 55020002", got); end
    total++; if (o_err_cnt !== 8'd3 || strobe_cnt != s0) begin
      bad++; $display("FAIL errors_side err=%0d strobes=%0d want 3/0", o_err_cnt, strobe_cnt - s0); end
    total++; if (o_ctrl_regs !== ctrl_vec()) begin bad++; $display("FAIL errors_ctrl got=%h want %h", o_ctrl_regs, ctrl_vec()); end
  endtask

  task automatic test_garbage_ping();
    logic [31:0] got, exp; bit ok, wr; int cnt, n;
    model_frame(8'h03, 8'h00, 8'h00, 8'h03, exp, wr);
    send_byte(8'h13);
    send_frame(8'h03, 8'h00, 8'h00, 8'h03);
    n = 0;
    while (txq.size() == 0 && n < 100) begin idle(1); n++; end
    // A full valid-looking frame arrives while the response is going out.
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00); send_byte(8'h03);
    wait_resp(got, ok, cnt);
    total++; if (!ok || got !== 32'h5500A5A5) begin bad++; $display("FAIL ping_resp got=%h want 5500a5a5", got); end
    idle(60);
    total++; if (txq.size() != 0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL dropped_extra bytes=%0d busy=%b want 0/0", txq.size(), o_busy); end
    txq.delete();
  endtask

  task automatic test_random();
    logic [31:0] got, exp; bit ok, wr; int cnt, s0;
    logic [7:0] c, a, d, k;
    for (int f = 0; f < 40; f++) begin
      for (int j = 0; j < NRO; j++) ro_m[j] = 8'($urandom_range(0, 255));
      drive_ro();
      case ($urandom_range(0, 7))
        0, 1, 7: c = 8'h01;
        2, 3:    c = 8'h02;
        4:       c = 8'h03;
        5:       c = 8'($urandom_range(4, 255));
        default: c = 8'h00;
      endcase
      case ($urandom_range(0, 4))
        0: a = 8'($urandom_range(0, NRO - 1));
        1: a = 8'(128 + $urandom_range(0, NCT - 1));
        2: a = 8'(NRO);
        3: a = 8'(128 + NCT);
        default: a = 8'($urandom_range(0, 255));
      endcase
      d = 8'($urandom_range(0, 255));
      k = c ^ a ^ d;
      if ($urandom_range(0, 7) == 0) k = k ^ 8'($urandom_range(1, 255));
      s0 = strobe_cnt;
      model_frame(c, a, d, k, exp, wr);
      send_frame(c, a, d, k);
      wait_resp(got, ok, cnt);
      total++; if (!ok || cnt != 4 || got !== exp) begin
        bad++; $display("FAIL rand_resp f=%0d frame=%h%h%h%h got=%h cnt=%0d want %h", f, c, a, d, k, got, cnt, exp); end
      total++; if (o_ctrl_regs !== ctrl_vec() || strobe_cnt - s0 != int'(wr)) begin
        bad++; $display("FAIL rand_ctrl f=%0d got=%h strobes=%0d want %h/%0d", f, o_ctrl_regs, strobe_cnt - s0, ctrl_vec(), wr); end
      total++; if (o_err_cnt !== 8'(err_m)) begin bad++; $display("FAIL rand_err f=%0d got=%0d want %0d", f, o_err_cnt, err_m); end
    end
  endtask

`ifdef UART_RESP_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] got, exp; bit ok, wr; int cnt;
    send_byte(8'hAA); send_byte(8'h01);
    idle(TO + 10);
    if (err_m != 255) err_m++;
    total++; if (o_busy !== 1'b0 || txq.size() != 0) begin
      bad++; $display("FAIL timeout_abort busy=%b bytes=%0d want 0/0", o_busy, txq.size()); end
    total++; if (o_err_cnt !== 8'(err_m)) begin bad++; $display("FAIL timeout_err got=%0d want %0d", o_err_cnt, err_m); end
    model_frame(8'h03, 8'h00, 8'h00, 8'h03, exp, wr);
    send_byte(8'hAA); send_byte(8'h03);
    idle(TO / 2);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
    wait_resp(got, ok, cnt);
    total++; if (!ok || got !== exp) begin bad++; $display("FAIL timeout_next got=%h want %h", got, exp); end
  endtask
`endif

  task automatic test_err_saturate();
    logic [31:0] got, exp; bit ok, wr; int cnt;
    for (int i = 0; i < 270 && err_m < 257; i++) begin
      model_frame(8'h01, 8'h00, 8'h00, 8'h5A, exp, wr);
      send_frame(8'h01, 8'h00, 8'h00, 8'h5A);
      wait_resp(got, ok, cnt);
      if (err_m == 255) break;
    end
    send_frame(8'h01, 8'h00, 8'h00, 8'h5A);
    wait_resp(got, ok, cnt);
    total++; if (o_err_cnt !== 8'hFF || got !== 32'h55010001) begin
      bad++; $display("FAIL err_saturate err=%h resp=%h want ff/55010001", o_err_cnt, got); end
  endtask

  task automatic test_reset_mid_response();
    logic [31:0] got, exp; bit ok, wr; int cnt, n;
    send_frame(8'h03, 8'h00, 8'h00, 8'h03);
    n = 0;
    while (o_tx_dv !== 1'b1 && n < 50) begin idle(1); n++; end
    total++; if (n >= 50) begin bad++; $display("FAIL midrst_start got=no_dv want dv"); end
    idle(1);
    i_rst_n = 1'b0;
    idle(2);
    total++; if (o_tx_dv !== 1'b0 || o_tx_byte !== 8'h00 || o_busy !== 1'b0 || o_wr_strobe !== 1'b0) begin
      bad++; $display("FAIL midrst_outs dv=%b byte=%h busy=%b strobe=%b want 0/00/0/0", o_tx_dv, o_tx_byte, o_busy, o_wr_strobe); end
    total++; if (o_ctrl_regs !== '0 || o_err_cnt !== 8'h00) begin
      bad++; $display("FAIL midrst_regs ctrl=%h err=%h want 0/00", o_ctrl_regs, o_err_cnt); end
    i_rst_n = 1'b1;
    for (int k = 0; k < NCT; k++) ctrl_m[k] = 8'h00;
    err_m = 0;
    txq.delete();
    idle(60);
    total++; if (txq.size() != 0) begin bad++; $display("FAIL midrst_no_resume bytes=%0d want 0", txq.size()); end
    txq.delete();
    model_frame(8'h01, 8'h05, 8'h00, 8'h04, exp, wr);
    send_frame(8'h01, 8'h05, 8'h00, 8'h04);
    wait_resp(got, ok, cnt);
    total++; if (!ok || got !== exp) begin bad++; $display("FAIL midrst_next got=%h want %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_errors();
    test_garbage_ping();
    test_random();
`ifdef UART_RESP_TIMEOUT_EN
    test_timeout();
`endif
    test_err_saturate();
    test_reset_mid_response();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Frame-level command responder on the FPGA side of the Pico UART link. It consumes the received-byte stream from the UART receiver, parses fixed 5-byte request frames sent by the Pico, and executes register reads, writes and pings. It then drives a 4-byte response frame into the UART transmitter's byte interface. It sits between `uart_top` and the health-monitor datapath: sensor status arrives as read-only registers, and control registers are written by the Pico.

## Interface
- `NUM_RO`, 8, number of read-only status registers (addresses 0x00..NUM_RO-1)
- `NUM_CTRL`, 4, number of read/write control registers (addresses 0x80..0x80+NUM_CTRL-1)
- `TIMEOUT_CLKS`, 25_000, maximum clocks between request bytes before the frame is abandoned
- `i_clk`  in  1  system clock
- `i_rst_n`  in  1  reset, synchronous, active-low
- `i_rx_dv`  in  1  one-cycle pulse; received byte valid
- `i_rx_byte`  in  8  received byte
- `o_tx_dv`  out  1  one-cycle pulse; start transmit of `o_tx_byte`
- `o_tx_byte`  out  8  byte to transmit
- `i_tx_active`  in  1  transmitter busy
- `i_tx_done`  in  1  one-cycle pulse; transmitter finished a byte
- `i_ro_regs`  in  8*NUM_RO  status registers; byte k at [8k+7:8k]
- `o_ctrl_regs`  out  8*NUM_CTRL  control registers, same packing
- `o_wr_strobe`  out  1  one-cycle pulse when a control register is written
- `o_busy`  out  1  high from SOF accepted until last response byte done
- `o_err_cnt`  out  8  saturating count of error responses

## Operation
- Request frame: `0xAA`, CMD, ADDR, DATA, CHK, where CHK = CMD^ADDR^DATA.
- Response frame: `0x55`, STATUS, RDATA, RCHK, where RCHK = STATUS^RDATA.
- CMD 0x01 READ: RDATA = register[ADDR]. DATA is ignored.
- CMD 0x02 WRITE: ctrl[ADDR-0x80] <= DATA; RDATA = DATA.
- CMD 0x03 PING: RDATA = 0xA5.
- STATUS values and their precedence: 0x01 bad checksum, then 0x02 unknown CMD, then 0x03 bad address (including WRITE to a read-only address), else 0x00 OK. When STATUS ≠ 0, RDATA = 0x00, no write occurs, and `o_err_cnt` increments, saturating at 0xFF.
- States:
  - S_SOF: a byte ≠ 0xAA is discarded silently.
  - S_CMD, S_ADDR, S_DATA, S_CHK: each advances on `i_rx_dv`.
  - S_EXEC: executes the command.
  - S_TX_LOAD: pulses `o_tx_dv`.
  - S_TX_WAIT: waits for `i_tx_done`. Returns to S_TX_LOAD for the next byte, or to S_SOF after byte 4.
- Bytes received during S_EXEC, S_TX_LOAD or S_TX_WAIT are dropped. There is no queueing.
- S_TX_LOAD issues `o_tx_dv` only when `i_tx_active`=0; otherwise it holds.
- `o_tx_byte` is held stable from the `o_tx_dv` pulse until `i_tx_done`.
- Reset values: `o_tx_dv`=0, `o_tx_byte`=0x00, `o_ctrl_regs`=0, `o_wr_strobe`=0, `o_busy`=0, `o_err_cnt`=0, state S_SOF.
- Reset mid-frame or mid-response: the block returns to S_SOF immediately. A partially sent response is not resumed.

## Timing
- A byte is accepted in the cycle `i_rx_dv`=1.
- CHK accepted in cycle N:
  - S_EXEC in N+1.
  - `o_ctrl_regs` and `o_wr_strobe` updated and visible in N+2.
  - First `o_tx_dv` in N+2 if the transmitter is idle.
- Each subsequent `o_tx_dv` follows `i_tx_done` by exactly 1 cycle, provided `i_tx_active`=0.
- `o_busy` rises the cycle after SOF is accepted. It falls the cycle after the 4th `i_tx_done`.
- `i_ro_regs` is sampled in S_EXEC only.
- `i_tx_done` arriving in S_TX_LOAD is ignored.

## Configuration
- `UART_RESP_TIMEOUT_EN` defined:
  - A 32-bit gap counter clears on every accepted byte and counts while in S_CMD..S_CHK.
  - When it reaches TIMEOUT_CLKS, the state returns to S_SOF with no response, and `o_err_cnt` increments.
- `UART_RESP_TIMEOUT_EN` undefined: there is no counter, and a partial frame waits indefinitely. `TIMEOUT_CLKS` is unused.

## Structure
- Package `uart_cmd_pkg` holds:
  - SOF constants 0xAA and 0x55
  - CMD enum (READ/WRITE/PING)
  - STATUS enum (OK/BAD_CHK/BAD_CMD/BAD_ADDR)
  - PING value 0xA5
  - CTRL_BASE 0x80
  - state typedef
- One natural sub-module: `uart_resp_serializer`, which takes a 4-byte response plus a start pulse and drives the `o_tx_dv`/`i_tx_done` handshake.

## Test plan
- Sensor register 2 = 0x3C; send `AA 01 02 00 03` → response `55 00 3C 3C`.
- Send `AA 02 81 7E FD` → ctrl[1]=0x7E with one `o_wr_strobe`; response `55 00 7E 7E`.
- Send `AA 01 02 00 00` (bad CHK) → response `55 01 00 01`; `o_err_cnt`=1; no write.
- Send `AA 02 03 11 10` (write to RO) → response `55 03 00 03`. Send CMD 0x07 → `55 02 00 02`.
- Leading garbage `13 AA 03 00 00 03` → exactly one response `55 00 A5 A5`. Extra bytes during the response are dropped.
- With `UART_RESP_TIMEOUT_EN` defined: send `AA 01`, stall TIMEOUT_CLKS → no response, `o_err_cnt`+1, next valid frame answered. Also assert reset mid-response → all outputs return to reset values.
